// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers of the 64-bit core:
// per-boundary control bundle layouts, bundle widths and bubble constants.
package pipe_pkg;

   // Defaults for a generic stage register instance.
   localparam int DEF_CTRL_W      = 16;
   localparam int DEF_DATA_W      = 256;
   localparam int DEF_STALL_CNT_W = 16;

   // IF/ID carries no datapath control yet, only the fetch prediction flag.
   typedef struct packed {
      logic pred_taken;
   } if_id_ctrl_t;

   // ID/EX carries the full decoded control set.
   typedef struct packed {
      logic       alu_src;
      logic       alu_src2;
      logic [2:0] alu_op;
      logic       mem_we;
      logic       mem2reg;
      logic       reg_we;
      logic       pc_src;
      logic       movz;
      logic       ldurb;
      logic [3:0] movk;
      logic [3:0] xfer_size;
   } id_ex_ctrl_t;

   // EX/MEM keeps only what memory access and writeback still need.
   typedef struct packed {
      logic       mem_we;
      logic       mem2reg;
      logic       reg_we;
      logic       pc_src;
      logic       ldurb;
      logic [3:0] xfer_size;
   } ex_mem_ctrl_t;

   // MEM/WB keeps only the writeback selection.
   typedef struct packed {
      logic mem2reg;
      logic reg_we;
      logic ldurb;
   } mem_wb_ctrl_t;

   localparam int IF_ID_CTRL_W  = $bits(if_id_ctrl_t);
   localparam int ID_EX_CTRL_W  = $bits(id_ex_ctrl_t);
   localparam int EX_MEM_CTRL_W = $bits(ex_mem_ctrl_t);
   localparam int MEM_WB_CTRL_W = $bits(mem_wb_ctrl_t);

   // instruction + pc
   localparam int IF_ID_DATA_W  = 32 + 64;
   // two operands, immediate, branch address
   localparam int ID_EX_DATA_W  = 4 * 64;
   // alu result, store data, branch address
   localparam int EX_MEM_DATA_W = 3 * 64;
   // memory read data, alu result
   localparam int MEM_WB_DATA_W = 2 * 64;

   // Bubbles: no register write, no memory access, no redirect.
   localparam if_id_ctrl_t  IF_ID_BUBBLE  = '0;
   localparam id_ex_ctrl_t  ID_EX_BUBBLE  = '0;
   localparam ex_mem_ctrl_t EX_MEM_BUBBLE = '0;
   localparam mem_wb_ctrl_t MEM_WB_BUBBLE = '0;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid bit plus control and data registers.
// Priority: flush > load > clear. Flush forces ctrl to the bubble value.
module pipe_slot #(
   parameter int                CTRL_W      = 16,
   parameter int                DATA_W      = 256,
   parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush_i,
   input  logic              load_i,
   input  logic              clear_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              valid_o,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic [DATA_W-1:0] data_o
);

   logic              valid_q, valid_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [DATA_W-1:0] data_q, data_d;

   // Next-state selection for the entry.
   always_comb begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
      data_d  = data_q;
      if (flush_i) begin
         valid_d = 1'b0;
         ctrl_d  = CTRL_BUBBLE;
      end else if (load_i) begin
         valid_d = 1'b1;
         ctrl_d  = ctrl_i;
         data_d  = data_i;
      end else if (clear_i) begin
         valid_d = 1'b0;
      end
   end

   // Entry registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         ctrl_q  <= CTRL_BUBBLE;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         ctrl_q  <= ctrl_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign ctrl_o  = ctrl_q;
   assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with flush/bubble insertion, optional
// skid entry and a saturating stall-cycle counter.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high on that side. A producer holding valid must keep its payload
// stable until the transfer; ready may depend on state only (SKID=1) or on
// out_ready combinationally (SKID=0). Output payload is bit-stable while
// out_valid=1 and out_ready=0.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int                CTRL_W      = DEF_CTRL_W,
   parameter int                DATA_W      = DEF_DATA_W,
   parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
   parameter int                SKID        = 0,
   parameter int                STALL_CNT_W = DEF_STALL_CNT_W
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [CTRL_W-1:0]      in_ctrl,
   input  logic [DATA_W-1:0]      in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [CTRL_W-1:0]      out_ctrl,
   output logic [DATA_W-1:0]      out_data,
   input  logic                   stall_clr,
   output logic [STALL_CNT_W-1:0] stall_cycles
);

   localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

   logic              in_xfer;
   logic              out_xfer;
   logic              main_valid;
   logic [CTRL_W-1:0] main_ctrl;
   logic [DATA_W-1:0] main_data;
   logic              main_load;
   logic              main_clear;
   logic [CTRL_W-1:0] main_ctrl_d;
   logic [DATA_W-1:0] main_data_d;

   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = main_valid & out_ready;

   generate
      if (SKID == 0) begin : g_single
         // Single entry: accept whenever the entry is empty or leaving.
         assign in_ready    = !main_valid | out_ready;
         assign main_load   = in_xfer;
         assign main_clear  = out_xfer & !in_xfer;
         assign main_ctrl_d = in_ctrl;
         assign main_data_d = in_data;
      end else begin : g_skid
         logic              skid_valid;
         logic [CTRL_W-1:0] skid_ctrl;
         logic [DATA_W-1:0] skid_data;
         logic              skid_load;
         logic              skid_clear;

         // in_ready is the inverse of a flop: no combinational path from out_ready.
         assign in_ready = !skid_valid;

         // Main refills from skid when draining; otherwise from the input when
         // it is empty or draining. skid_valid implies in_ready=0, so the two
         // sources never compete.
         assign main_load   = (out_xfer & skid_valid) |
                              (in_xfer & (!main_valid | out_xfer));
         assign main_clear  = out_xfer & !main_load;
         assign main_ctrl_d = skid_valid ? skid_ctrl : in_ctrl;
         assign main_data_d = skid_valid ? skid_data : in_data;

         // Skid catches an entry arriving while main is occupied and stalled.
         assign skid_load  = in_xfer & main_valid & !out_xfer;
         assign skid_clear = out_xfer & skid_valid;

         pipe_slot #(
            .CTRL_W      (CTRL_W),
            .DATA_W      (DATA_W),
            .CTRL_BUBBLE (CTRL_BUBBLE)
         ) u_skid (
            .clk     (clk),
            .rst_n   (reset),
            .flush_i (flush),
            .load_i  (skid_load),
            .clear_i (skid_clear),
            .ctrl_i  (in_ctrl),
            .data_i  (in_data),
            .valid_o (skid_valid),
            .ctrl_o  (skid_ctrl),
            .data_o  (skid_data)
         );
      end
   endgenerate

   pipe_slot #(
      .CTRL_W      (CTRL_W),
      .DATA_W      (DATA_W),
      .CTRL_BUBBLE (CTRL_BUBBLE)
   ) u_main (
      .clk     (clk),
      .rst_n   (reset),
      .flush_i (flush),
      .load_i  (main_load),
      .clear_i (main_clear),
      .ctrl_i  (main_ctrl_d),
      .data_i  (main_data_d),
      .valid_o (main_valid),
      .ctrl_o  (main_ctrl),
      .data_o  (main_data)
   );

   // Downstream never sees stale control on an empty stage.
   assign out_valid = main_valid;
   assign out_ctrl  = main_valid ? main_ctrl : CTRL_BUBBLE;
   assign out_data  = main_data;

   logic [STALL_CNT_W-1:0] stall_q, stall_d;

   // Saturating count of stalled output cycles; clear wins over increment.
   always_comb begin
      stall_d = stall_q;
      if (stall_clr) begin
         stall_d = '0;
      end else if (main_valid && !out_ready && (stall_q != '1)) begin
         stall_d = stall_q + STALL_ONE;
      end
   end

   // Stall counter register; flush leaves it untouched.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances share one stimulus stream
// (SKID=0, SKID=1, SKID=0 with a 4-bit stall counter).
module tb_pipe_stage_reg;

   localparam int          CW     = 16;
   localparam int          DW     = 32;
   localparam logic [15:0] BUBBLE = 16'hB000;

   logic          clk;
   logic          reset;
   logic          flush;
   logic          in_valid;
   logic [CW-1:0] in_ctrl;
   logic [DW-1:0] in_data;
   logic          out_ready;
   logic          stall_clr;

   logic          d0_in_ready, d0_out_valid;
   logic [CW-1:0] d0_out_ctrl;
   logic [DW-1:0] d0_out_data;
   logic [15:0]   d0_stall;
   logic          d1_in_ready, d1_out_valid;
   logic [CW-1:0] d1_out_ctrl;
   logic [DW-1:0] d1_out_data;
   logic [15:0]   d1_stall;
   logic          d2_in_ready, d2_out_valid;
   logic [CW-1:0] d2_out_ctrl;
   logic [DW-1:0] d2_out_data;
   logic [3:0]    d2_stall;

   int checks   = 0;
   int failures = 0;

   logic [CW+DW-1:0] exp_q0[$];
   logic [CW+DW-1:0] exp_q1[$];

   pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CTRL_BUBBLE(BUBBLE), .SKID(0), .STALL_CNT_W(16)) dut0 (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(d0_in_ready),
      .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(d0_out_valid), .out_ready(out_ready),
      .out_ctrl(d0_out_ctrl), .out_data(d0_out_data), .stall_clr(stall_clr), .stall_cycles(d0_stall));

   pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CTRL_BUBBLE(BUBBLE), .SKID(1), .STALL_CNT_W(16)) dut1 (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(d1_in_ready),
      .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(d1_out_valid), .out_ready(out_ready),
      .out_ctrl(d1_out_ctrl), .out_data(d1_out_data), .stall_clr(stall_clr), .stall_cycles(d1_stall));

   pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CTRL_BUBBLE(BUBBLE), .SKID(0), .STALL_CNT_W(4)) dut2 (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(d2_in_ready),
      .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(d2_out_valid), .out_ready(out_ready),
      .out_ctrl(d2_out_ctrl), .out_data(d2_out_data), .stall_clr(stall_clr), .stall_cycles(d2_stall));

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard step, called at the negedge while inputs are stable.
   task automatic sb_step();
      logic [CW+DW-1:0] e;
      check("bubble0", d0_out_valid ? BUBBLE : d0_out_ctrl, BUBBLE);
      check("bubble1", d1_out_valid ? BUBBLE : d1_out_ctrl, BUBBLE);
      if (flush) begin
         exp_q0.delete();
         exp_q1.delete();
      end else begin
         if (d0_out_valid && out_ready) begin
            check("sb0_nonempty", exp_q0.size() != 0, 1);
            if (exp_q0.size() != 0) begin
               e = exp_q0.pop_front();
               check("sb0_out", {d0_out_ctrl, d0_out_data}, e);
            end
         end
         if (in_valid && d0_in_ready) exp_q0.push_back({in_ctrl, in_data});
         if (d1_out_valid && out_ready) begin
            check("sb1_nonempty", exp_q1.size() != 0, 1);
            if (exp_q1.size() != 0) begin
               e = exp_q1.pop_front();
               check("sb1_out", {d1_out_ctrl, d1_out_data}, e);
            end
         end
         if (in_valid && d1_in_ready) exp_q1.push_back({in_ctrl, in_data});
      end
   endtask

   typedef struct {
      logic          vin;
      logic [CW-1:0] ctrl;
      logic [DW-1:0] data;
      logic          ordy;
      logic          fl;
      logic          exp_valid;
      logic [CW-1:0] exp_ctrl;
      logic          chk_data;
      logic [DW-1:0] exp_data;
      logic          exp_ready;
   } vec_t;

   vec_t vecs[8];
   logic [31:0] seq;

   initial begin
      // Vectors for dut0: stream, idle, load, flush with incoming entry, idle.
      vecs[0] = '{1'b1, 16'h0101, 32'h1, 1'b1, 1'b0, 1'b1, 16'h0101, 1'b1, 32'h1, 1'b1};
      vecs[1] = '{1'b1, 16'h0102, 32'h2, 1'b1, 1'b0, 1'b1, 16'h0102, 1'b1, 32'h2, 1'b1};
      vecs[2] = '{1'b1, 16'h0103, 32'h3, 1'b1, 1'b0, 1'b1, 16'h0103, 1'b1, 32'h3, 1'b1};
      vecs[3] = '{1'b1, 16'h0104, 32'h4, 1'b1, 1'b0, 1'b1, 16'h0104, 1'b1, 32'h4, 1'b1};
      vecs[4] = '{1'b0, 16'h0000, 32'h0, 1'b1, 1'b0, 1'b0, BUBBLE,   1'b0, 32'h0, 1'b1};
      vecs[5] = '{1'b1, 16'h00FF, 32'h77, 1'b0, 1'b0, 1'b1, 16'h00FF, 1'b1, 32'h77, 1'b0};
      vecs[6] = '{1'b1, 16'h0033, 32'hDEAD, 1'b1, 1'b1, 1'b0, BUBBLE, 1'b0, 32'h0, 1'b1};
      vecs[7] = '{1'b0, 16'h0000, 32'h0, 1'b1, 1'b0, 1'b0, BUBBLE,   1'b0, 32'h0, 1'b1};

      // Reset block
      reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0;
      out_ready = 1'b1; stall_clr = 1'b0; seq = 32'h1000;
      repeat (2) @(negedge clk);
      check("rst_valid0", d0_out_valid, 0);
      check("rst_ctrl0", d0_out_ctrl, BUBBLE);
      check("rst_data0", d0_out_data, 0);
      check("rst_stall0", d0_stall, 0);
      check("rst_valid1", d1_out_valid, 0);
      check("rst_ctrl1", d1_out_ctrl, BUBBLE);
      reset = 1'b1;
      tick();
      check("rel_ready0", d0_in_ready, 1);
      check("rel_ready1", d1_in_ready, 1);

      // Asynchronous reset in the middle of a stall.
      in_valid = 1'b1; in_ctrl = 16'h0042; in_data = 32'h99; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      check("pre_arst_valid0", d0_out_valid, 1);
      #3 reset = 1'b0;
      #1;
      check("arst_valid0", d0_out_valid, 0);
      check("arst_ctrl0", d0_out_ctrl, BUBBLE);
      check("arst_data0", d0_out_data, 0);
      check("arst_valid1", d1_out_valid, 0);
      check("arst_data1", d1_out_data, 0);
      #2 reset = 1'b1;
      out_ready = 1'b1;
      tick();
      check("post_arst_ready0", d0_in_ready, 1);
      check("post_arst_valid0", d0_out_valid, 0);

      // Table-driven vectors on the single-entry instance.
      for (int i = 0; i < 8; i++) begin
         in_valid = vecs[i].vin; in_ctrl = vecs[i].ctrl; in_data = vecs[i].data;
         out_ready = vecs[i].ordy; flush = vecs[i].fl;
         tick();
         check($sformatf("v%0d_valid", i), d0_out_valid, vecs[i].exp_valid);
         check($sformatf("v%0d_ctrl", i), d0_out_ctrl, vecs[i].exp_ctrl);
         if (vecs[i].chk_data) check($sformatf("v%0d_data", i), d0_out_data, vecs[i].exp_data);
         check($sformatf("v%0d_ready", i), d0_in_ready, vecs[i].exp_ready);
      end
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;

      // Stall hold and counter.
      stall_clr = 1'b1;
      tick();
      stall_clr = 1'b0;
      in_valid = 1'b1; in_ctrl = 16'h0025; in_data = 32'h55; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("stall_ctrl", d0_out_ctrl, 16'h0025);
         check("stall_data", d0_out_data, 32'h55);
         check("stall_valid", d0_out_valid, 1);
         check("stall_ready", d0_in_ready, 0);
      end
      check("stall_cnt5_d0", d0_stall, 5);
      check("stall_cnt5_d2", d2_stall, 5);
      stall_clr = 1'b1;
      tick();
      stall_clr = 1'b0;
      check("stall_clr_d0", d0_stall, 0);
      repeat (20) tick();
      check("stall_cnt20_d0", d0_stall, 20);
      check("stall_sat_d2", d2_stall, 15);
      stall_clr = 1'b1;
      tick();
      stall_clr = 1'b0;
      check("clr_wins_d0", d0_stall, 0);
      check("clr_wins_d2", d2_stall, 0);
      out_ready = 1'b1;
      tick();
      check("stall_drain_valid0", d0_out_valid, 0);
      check("stall_drain_valid1", d1_out_valid, 0);

      // Skid entry fill and drain.
      out_ready = 1'b0;
      in_valid = 1'b1; in_ctrl = 16'h000A; in_data = 32'hA;
      tick();
      in_ctrl = 16'h000B; in_data = 32'hB;
      tick();
      in_valid = 1'b0;
      check("skid_main_data", d1_out_data, 32'hA);
      check("skid_main_valid", d1_out_valid, 1);
      check("skid_full_ready", d1_in_ready, 0);
      out_ready = 1'b1;
      tick();
      check("skid_b_data", d1_out_data, 32'hB);
      check("skid_b_valid", d1_out_valid, 1);
      check("skid_ready_back", d1_in_ready, 1);
      tick();
      check("skid_empty_valid", d1_out_valid, 0);
      check("skid_empty_ctrl", d1_out_ctrl, BUBBLE);

      // Random valid/ready with occasional flush and counter clear.
      for (int c = 0; c < 10000; c++) begin
         @(posedge clk);
         #1;
         in_valid  = 1'($urandom_range(0, 1));
         in_ctrl   = 16'($urandom_range(0, 16'hFFFF));
         in_data   = seq;
         seq       = seq + 32'd1;
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 63) == 0);
         stall_clr = ($urandom_range(0, 31) == 0);
         @(negedge clk);
         sb_step();
      end

      // Drain with a bounded cycle budget.
      @(posedge clk);
      #1;
      in_valid = 1'b0; flush = 1'b0; stall_clr = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         sb_step();
         @(posedge clk);
         #1;
      end
      check("sb0_drained", exp_q0.size(), 0);
      check("sb1_drained", exp_q1.size(), 0);
      check("end_valid0", d0_out_valid, 0);
      check("end_valid1", d1_out_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
